// File: rtl/sprite_line_engine.sv
// sprite_line_engine
// Foreground sprite scanline engine. Each prefetch request builds one
// 256-pixel line of objects into a round-robin line buffer by scanning the
// object attribute memory (OBM) and fetching pattern rows (PMF). Lower object
// index has priority. At most MAX_PER_LINE objects are drawn per line; extra
// hits raise the overflow flag. The display side picks the buffer tagged with
// the current display line and outputs 2-bit RGB plus valid, registered once.
//
// Ports:
//   gpu_clk, rst              clock, synchronous active-high reset
//   prefetch_start_i/y_i      one-cycle build request and the line to build
//   busy_o, done_o            build in progress / one-cycle completion pulse
//   overflow_o                last completed line had too many hits
//   obm_addr_o, obm_data_i    OBM read port (data one cycle after address)
//   pmf_addr_o, pmf_data_i    pattern read port (data one cycle after address)
//   display_x_i, display_y_i  current display coordinate
//   r_o, g_o, b_o, valid_o    foreground pixel, one cycle after the coordinate
module sprite_line_engine #(
    parameter int NUM_OBJECTS   = 64,
    parameter int NUM_LINE_BUFS = 2,
    parameter int MAX_PER_LINE  = 16,
    localparam int OBJ_W = $clog2(NUM_OBJECTS),
    localparam int BUF_W = $clog2(NUM_LINE_BUFS),
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1)
) (
    input  logic             gpu_clk,
    input  logic             rst,
    input  logic             prefetch_start_i,
    input  logic [7:0]       prefetch_y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic [OBJ_W-1:0] obm_addr_o,
    input  logic [31:0]      obm_data_i,
    output logic [7:0]       pmf_addr_o,
    input  logic [15:0]      pmf_data_i,
    input  logic [7:0]       display_x_i,
    input  logic [7:0]       display_y_i,
    output logic [1:0]       r_o,
    output logic [1:0]       g_o,
    output logic [1:0]       b_o,
    output logic             valid_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ADDR, S_EVAL, S_PAT, S_DRAW
    } state_t;

    state_t state_q, state_d;

    // Line buffer entries are {lightness[1:0], rgb[2:0]}
    logic [4:0] lbuf [NUM_LINE_BUFS][256];
    logic [7:0] tag_q [NUM_LINE_BUFS];
    logic [NUM_LINE_BUFS-1:0] tag_vld_q;

    logic [BUF_W-1:0] rptr_q, rptr_next;
    logic [7:0]       line_y_q;
    logic [7:0]       clr_k_q;
    logic [OBJ_W-1:0] obj_j_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic             ovf_q;
    logic             overflow_q;
    logic             done_q;
    logic [7:0]       pmf_addr_q;
    logic [2:0]       draw_i_q;

    // Attributes of the object being drawn, captured in EVAL
    logic [7:0]  obj_x_q;
    logic        obj_hflip_q;
    logic [2:0]  obj_rgb_q;
    logic [15:0] pat_q;

    // FSM strobes
    logic start_acc, draw_hit, ovf_set, obj_done;

    // Object evaluation
    logic [7:0] obj_y;
    logic [8:0] dy9;
    logic       obj_hit, cnt_full, last_obj;
    logic [2:0] row;

    assign obj_y    = obm_data_i[23:16];
    assign dy9      = {1'b0, line_y_q} - {1'b0, obj_y};
    // Borrow set means line_y < obj.y, so sprites never wrap vertically
    assign obj_hit  = ~dy9[8] && (dy9[7:3] == 5'd0);
    assign cnt_full = (hit_cnt_q == CNT_W'(MAX_PER_LINE));
    assign last_obj = (obj_j_q == OBJ_W'(NUM_OBJECTS - 1));
    assign row      = obm_data_i[9] ? (3'd7 - dy9[2:0]) : dy9[2:0];
    assign rptr_next = (rptr_q == BUF_W'(NUM_LINE_BUFS - 1)) ? '0 : rptr_q + BUF_W'(1);

    // Pixel draw: pattern word arrives in the first DRAW cycle and is held
    logic [15:0] pat_word;
    logic [2:0]  shift;
    logic [1:0]  pix_l;
    logic [8:0]  tx9;
    logic [4:0]  existing;
    logic        draw_we, clr_we;

    assign pat_word = (draw_i_q == 3'd0) ? pmf_data_i : pat_q;
    // Pixel i sits at bit (7-i)*2; with hflip the source column is 7-i,
    // which collapses the shift to i itself
    assign shift    = obj_hflip_q ? draw_i_q : (3'd7 - draw_i_q);
    assign pix_l    = pat_word[{shift, 1'b0} +: 2];
    assign tx9      = {1'b0, obj_x_q} + {6'd0, draw_i_q};
    assign existing = lbuf[rptr_q][tx9[7:0]];
    assign draw_we  = (state_q == S_DRAW) && !tx9[8] && (pix_l != 2'd0)
                      && (existing[4:3] == 2'd0);
    assign clr_we   = (state_q == S_CLEAR);

    always_ff @(posedge gpu_clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        draw_hit  = 1'b0;
        ovf_set   = 1'b0;
        obj_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prefetch_start_i) begin
                    start_acc = 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_k_q == 8'd255) state_d = S_ADDR;
            end
            S_ADDR:  state_d = S_EVAL;
            S_EVAL: begin
                if (obj_hit && !cnt_full) begin
                    draw_hit = 1'b1;
                    state_d  = S_PAT;
                end else begin
                    ovf_set  = obj_hit;
                    obj_done = 1'b1;
                end
            end
            S_PAT:   state_d = S_DRAW;
            S_DRAW: begin
                if (draw_i_q == 3'd7) obj_done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (obj_done) state_d = last_obj ? S_IDLE : S_ADDR;
    end

    // Build control
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            rptr_q     <= BUF_W'(NUM_LINE_BUFS - 1);
            tag_vld_q  <= '0;
            clr_k_q    <= '0;
            obj_j_q    <= '0;
            hit_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            pmf_addr_q <= '0;
            draw_i_q   <= '0;
        end else begin
            done_q <= obj_done && last_obj;
            if (start_acc) begin
                rptr_q               <= rptr_next;
                tag_vld_q[rptr_next] <= 1'b0;
                hit_cnt_q            <= '0;
                ovf_q                <= 1'b0;
                clr_k_q              <= '0;
                obj_j_q              <= '0;
            end
            if (clr_we) clr_k_q <= clr_k_q + 8'd1;
            if (draw_hit) begin
                hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
                pmf_addr_q <= {obm_data_i[15:11], row};
                draw_i_q   <= '0;
            end
            if (state_q == S_DRAW) draw_i_q <= draw_i_q + 3'd1;
            if (ovf_set) ovf_q <= 1'b1;
            if (obj_done) begin
                if (last_obj) begin
                    tag_vld_q[rptr_q] <= 1'b1;
                    overflow_q        <= ovf_q | ovf_set;
                    obj_j_q           <= '0;
                end else begin
                    obj_j_q <= obj_j_q + OBJ_W'(1);
                end
            end
        end
    end

    // Build datapath
    always_ff @(posedge gpu_clk) begin
        if (start_acc) begin
            tag_q[rptr_next] <= prefetch_y_i;
            line_y_q         <= prefetch_y_i;
        end
        if (draw_hit) begin
            obj_x_q     <= obm_data_i[31:24];
            obj_hflip_q <= obm_data_i[8];
            obj_rgb_q   <= obm_data_i[2:0];
        end
        if (state_q == S_DRAW) pat_q <= pat_word;
        if (clr_we)       lbuf[rptr_q][clr_k_q]  <= 5'd0;
        else if (draw_we) lbuf[rptr_q][tx9[7:0]] <= {pix_l, obj_rgb_q};
    end

    // Display lookup, stage p0: lowest-index buffer whose tag matches wins
    logic             disp_match;
    logic [BUF_W-1:0] disp_sel;
    logic [4:0]       disp_ent;
    logic             disp_on;

    always_comb begin
        disp_match = 1'b0;
        disp_sel   = '0;
        for (int b = NUM_LINE_BUFS - 1; b >= 0; b--) begin
            if (tag_vld_q[b] && (tag_q[b] == display_y_i)) begin
                disp_match = 1'b1;
                disp_sel   = BUF_W'(b);
            end
        end
    end

    assign disp_ent = lbuf[disp_sel][display_x_i];
    assign disp_on  = disp_match && (disp_ent[4:3] != 2'd0);

    // Display stage p1: registered pixel
    logic       vld_p1;
    logic [1:0] r_p1, g_p1, b_p1;

    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            r_p1   <= '0;
            g_p1   <= '0;
            b_p1   <= '0;
        end else begin
            vld_p1 <= disp_on;
            r_p1   <= disp_on ? (disp_ent[4:3] & {2{disp_ent[2]}}) : 2'd0;
            g_p1   <= disp_on ? (disp_ent[4:3] & {2{disp_ent[1]}}) : 2'd0;
            b_p1   <= disp_on ? (disp_ent[4:3] & {2{disp_ent[0]}}) : 2'd0;
        end
    end

    // conf[2] and color[7:3] carry no meaning for this engine
    logic unused_bits;
    assign unused_bits = ^{obm_data_i[10], obm_data_i[7:3]};

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign overflow_o = overflow_q;
    assign obm_addr_o = obj_j_q;
    assign pmf_addr_o = pmf_addr_q;
    assign valid_o    = vld_p1;
    assign r_o        = r_p1;
    assign g_o        = g_p1;
    assign b_o        = b_p1;

endmodule

// File: tb/tb_sprite_line_engine.sv
// Testbench for sprite_line_engine: directed scenes plus randomized scenes,
// checked against a behavioural line model and buffer-tag model.
module tb_sprite_line_engine;
    localparam int NO  = 64;
    localparam int NB  = 2;
    localparam int MPL = 2;

    logic        gpu_clk = 1'b0;
    logic        rst = 1'b1;
    logic        prefetch_start = 1'b0;
    logic [7:0]  prefetch_y = 8'd0;
    logic        busy_o, done_o, overflow_o;
    logic [5:0]  obm_addr;
    logic [31:0] obm_data;
    logic [7:0]  pmf_addr;
    logic [15:0] pmf_data;
    logic [7:0]  display_x = 8'd0;
    logic [7:0]  display_y = 8'd0;
    logic [1:0]  r_o, g_o, b_o;
    logic        valid_o;

    always #5 gpu_clk = ~gpu_clk;

    sprite_line_engine #(.NUM_OBJECTS(NO), .NUM_LINE_BUFS(NB), .MAX_PER_LINE(MPL)) dut (
        .gpu_clk(gpu_clk), .rst(rst),
        .prefetch_start_i(prefetch_start), .prefetch_y_i(prefetch_y),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o),
        .obm_addr_o(obm_addr), .obm_data_i(obm_data),
        .pmf_addr_o(pmf_addr), .pmf_data_i(pmf_data),
        .display_x_i(display_x), .display_y_i(display_y),
        .r_o(r_o), .g_o(g_o), .b_o(b_o), .valid_o(valid_o)
    );

    // Synchronous VRAM
    logic [31:0] obm_mem [NO];
    logic [15:0] pmf_mem [256];
    always @(posedge gpu_clk) begin
        obm_data <= obm_mem[obm_addr];
        pmf_data <= pmf_mem[pmf_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: buffers as the display should see them
    logic [4:0] exp_buf [NB][256];
    logic [7:0] exp_tag [NB];
    bit         exp_tv [NB];
    int         exp_rp;
    logic [4:0] mdl_line [256];
    bit         mdl_ovf;
    int         mdl_drawn;

    function automatic logic [31:0] mk_obj(int x, int y, int pmfa, bit vf, bit hf, int rgb);
        return {8'(x), 8'(y), 5'(pmfa), 1'b0, vf, hf, 5'd0, 3'(rgb)};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) exp_tv[b] = 1'b0;
        exp_rp = NB - 1;
    endtask

    // Line content from the object rules, in scan order
    task automatic model_line(input int line);
        logic [31:0] o;
        logic [15:0] pat;
        int ox, oy, dy, rw, col, l, x;
        for (int k = 0; k < 256; k++) mdl_line[k] = 5'd0;
        mdl_ovf = 1'b0;
        mdl_drawn = 0;
        for (int j = 0; j < NO; j++) begin
            o  = obm_mem[j];
            ox = int'(o[31:24]);
            oy = int'(o[23:16]);
            if (line >= oy && line - oy < 8) begin
                if (mdl_drawn < MPL) begin
                    mdl_drawn++;
                    dy  = line - oy;
                    rw  = o[9] ? 7 - dy : dy;
                    pat = pmf_mem[int'(o[15:11]) * 8 + rw];
                    for (int i = 0; i < 8; i++) begin
                        col = o[8] ? 7 - i : i;
                        l   = int'((pat >> ((7 - col) * 2)) & 16'h3);
                        x   = ox + i;
                        if (x < 256 && l != 0 && mdl_line[x][4:3] == 2'd0)
                            mdl_line[x] = {2'(l), o[2:0]};
                    end
                end else begin
                    mdl_ovf = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [6:0] exp_pix(int x, int y);
        logic [4:0] e;
        for (int b = 0; b < NB; b++) begin
            if (exp_tv[b] && exp_tag[b] == 8'(y)) begin
                e = exp_buf[b][x];
                if (e[4:3] == 2'd0) return 7'd0;
                return {1'b1, e[4:3] & {2{e[2]}}, e[4:3] & {2{e[1]}}, e[4:3] & {2{e[0]}}};
            end
        end
        return 7'd0;
    endfunction

    // Compare process: checks every displayed pixel while scanning
    bit         chk_en = 1'b0;
    bit         smp_en = 1'b0;
    logic [7:0] smp_x, smp_y;
    always @(posedge gpu_clk) begin
        smp_x  <= display_x;
        smp_y  <= display_y;
        smp_en <= chk_en;
    end
    always @(negedge gpu_clk) begin
        if (smp_en)
            chk($sformatf("pix x=%0d y=%0d", smp_x, smp_y),
                {25'd0, valid_o, r_o, g_o, b_o}, {25'd0, exp_pix(int'(smp_x), int'(smp_y))});
    end

    task automatic do_reset();
        @(posedge gpu_clk); #1;
        rst = 1'b1;
        @(posedge gpu_clk); #1;
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst overflow", overflow_o, 0);
        chk("rst pixel", {valid_o, r_o, g_o, b_o}, 0);
        chk("rst obm_addr", obm_addr, 0);
        chk("rst pmf_addr", pmf_addr, 0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic clear_scene();
        for (int j = 0; j < NO; j++) obm_mem[j] = mk_obj(0, 8'hF0, 0, 0, 0, 0);
        for (int k = 0; k < 256; k++) pmf_mem[k] = 16'h0000;
    endtask

    task automatic do_build(input int line, input bit stray, output int lat);
        int n;
        bit got;
        model_line(line);
        @(posedge gpu_clk); #1;
        prefetch_start = 1'b1;
        prefetch_y = 8'(line);
        exp_rp = (exp_rp + 1) % NB;
        exp_tv[exp_rp] = 1'b0;
        exp_tag[exp_rp] = 8'(line);
        n = 0;
        got = 1'b0;
        while (n < 3000 && !got) begin
            @(posedge gpu_clk); #1;
            n++;
            prefetch_start = 1'b0;
            if (n == 1) chk("busy at t+1", busy_o, 1);
            if (stray && n == 100) begin
                prefetch_start = 1'b1;
                prefetch_y = ~8'(line);
            end
            if (done_o) got = 1'b1;
        end
        lat = n;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL build timeout line %0d: no done after %0d cycles", line, n);
        end else begin
            chk($sformatf("done latency line %0d", line), lat, 257 + 2 * NO + 9 * mdl_drawn);
            chk($sformatf("overflow line %0d", line), overflow_o, mdl_ovf);
            chk("busy low at done", busy_o, 0);
            @(posedge gpu_clk); #1;
            chk("done one cycle", done_o, 0);
        end
        for (int k = 0; k < 256; k++) exp_buf[exp_rp][k] = mdl_line[k];
        exp_tv[exp_rp] = 1'b1;
    endtask

    task automatic scan_line(input int y);
        for (int x = 0; x < 256; x++) begin
            @(posedge gpu_clk); #1;
            display_x = 8'(x);
            display_y = 8'(y);
            chk_en = 1'b1;
        end
        @(posedge gpu_clk); #1;
        chk_en = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input logic [6:0] e, input string nm);
        @(posedge gpu_clk); #1;
        display_x = 8'(x);
        display_y = 8'(y);
        @(posedge gpu_clk); #1;
        chk(nm, {25'd0, valid_o, r_o, g_o, b_o}, {25'd0, e});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ln, nh, idx;
        model_reset();
        clear_scene();

        // No objects on the line
        do_reset();
        do_build(10, 1'b0, lat);
        chk("empty latency", lat, 385);
        chk("empty overflow", overflow_o, 0);
        probe(100, 10, 7'd0, "empty (100,10)");
        scan_line(10);

        // Single opaque object
        do_reset();
        clear_scene();
        obm_mem[0] = mk_obj(100, 10, 1, 0, 0, 3'b101);
        pmf_mem[8] = 16'hFFFF;
        do_build(10, 1'b0, lat);
        chk("single latency", lat, 394);
        probe(100, 10, 7'b1_11_00_11, "single (100,10)");
        probe(107, 10, 7'b1_11_00_11, "single (107,10)");
        probe(99, 10, 7'd0, "single (99,10)");
        probe(108, 10, 7'd0, "single (108,10)");
        scan_line(10);

        // Overlap: lower index wins
        do_reset();
        clear_scene();
        obm_mem[0] = mk_obj(50, 30, 2, 0, 0, 3'b100);
        obm_mem[1] = mk_obj(52, 30, 3, 0, 0, 3'b011);
        pmf_mem[16] = 16'hFFFF;
        pmf_mem[24] = 16'hAAAA;
        do_build(30, 1'b0, lat);
        probe(55, 30, 7'b1_11_00_00, "overlap (55,30)");
        probe(58, 30, 7'b1_00_10_10, "overlap (58,30)");
        probe(60, 30, 7'd0, "overlap (60,30)");
        scan_line(30);

        // vflip + hflip
        do_reset();
        clear_scene();
        obm_mem[0] = mk_obj(40, 20, 4, 1, 1, 3'b111);
        pmf_mem[32] = 16'hC000;
        do_build(27, 1'b0, lat);
        probe(47, 27, 7'b1_11_11_11, "flip (47,27)");
        probe(40, 27, 7'd0, "flip (40,27)");
        scan_line(27);

        // Horizontal and vertical edges
        do_reset();
        clear_scene();
        obm_mem[0] = mk_obj(252, 100, 5, 0, 0, 3'b010);
        obm_mem[2] = mk_obj(10, 8'hFF, 5, 0, 0, 3'b001);
        pmf_mem[40] = 16'hFFFF;
        do_build(100, 1'b0, lat);
        probe(255, 100, 7'b1_00_11_00, "edge (255,100)");
        probe(0, 100, 7'd0, "edge no wrap (0,100)");
        scan_line(100);
        do_build(255, 1'b0, lat);
        probe(10, 255, 7'b1_00_00_11, "y=FF on line 255");
        do_build(0, 1'b0, lat);
        probe(10, 0, 7'd0, "y=FF not on line 0");
        scan_line(0);

        // Sprite limit with a start ignored while busy
        do_reset();
        clear_scene();
        obm_mem[0] = mk_obj(0, 60, 6, 0, 0, 3'b111);
        obm_mem[1] = mk_obj(20, 60, 6, 0, 0, 3'b100);
        obm_mem[2] = mk_obj(40, 60, 6, 0, 0, 3'b001);
        pmf_mem[48] = 16'hFFFF;
        do_build(60, 1'b1, lat);
        chk("limit latency", lat, 403);
        chk("limit overflow", overflow_o, 1);
        probe(0, 60, 7'b1_11_11_11, "limit obj0");
        probe(20, 60, 7'b1_11_00_00, "limit obj1");
        probe(40, 60, 7'd0, "limit obj2 dropped");
        scan_line(60);
        do_build(100, 1'b0, lat);
        chk("overflow cleared", overflow_o, 0);
        probe(0, 60, 7'b1_11_11_11, "buffer kept after stray start");

        // Reset in the middle of CLEAR
        do_reset();
        do_build(60, 1'b0, lat);
        do_build(60, 1'b0, lat);
        @(posedge gpu_clk); #1;
        prefetch_start = 1'b1;
        prefetch_y = 8'd61;
        @(posedge gpu_clk); #1;
        prefetch_start = 1'b0;
        repeat (40) @(posedge gpu_clk);
        #1;
        display_x = 8'd0;
        display_y = 8'd60;
        @(posedge gpu_clk); #1;
        chk("busy before mid reset", busy_o, 1);
        chk("valid before mid reset", valid_o, 1);
        rst = 1'b1;
        @(posedge gpu_clk); #1;
        chk("busy after mid reset", busy_o, 0);
        chk("valid after mid reset", valid_o, 0);
        rst = 1'b0;
        model_reset();

        // Randomized scenes
        do_reset();
        for (int it = 0; it < 8; it++) begin
            ln = int'($urandom_range(0, 255));
            for (int j = 0; j < NO; j++)
                obm_mem[j] = $urandom;
            for (int k = 0; k < 256; k++) pmf_mem[k] = 16'($urandom);
            nh = int'($urandom_range(0, 4));
            for (int h = 0; h < nh; h++) begin
                idx = int'($urandom_range(0, NO - 1));
                obm_mem[idx][23:16] = 8'((ln >= 7) ? ln - int'($urandom_range(0, 7)) : ln);
            end
            do_build(ln, ($urandom_range(0, 1) == 1), lat);
            scan_line(ln);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
